// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - z, with borrow-out b.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic b
);

    assign d = x ^ y ^ z;
    assign b = (~x & y) | (~x & z) | (y & z);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: computes diff = a - b - bin, LSB first,
// by time-sharing one full_sub_cell over WIDTH cycles.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_b;
    logic             last_bit;
    logic [WIDTH-1:0] d_shift;

    full_sub_cell u_cell (
        .x (a_sr[0]),
        .y (b_sr[0]),
        .z (borrow),
        .d (cell_d),
        .b (cell_b)
    );

    assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);
    assign d_shift  = {cell_d, d_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result registers are written only on the DONE-entry edge, using the
    // shifted value so the final bit is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            borrow <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    d_sr   <= d_shift;
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    borrow <= cell_b;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff <= d_shift;
                        bout <= cell_b;
                        ovf  <= (a_msb != b_msb) && (d_shift[WIDTH-1] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT) || (state == DONE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard testbench for serial_sub_ctrl: directed operations push expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        int unsigned      acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    exp_t        sb[$];

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one operation; operands are scrambled right after acceptance.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic binv, input logic [WIDTH-1:0] ed,
                                 input logic eb, input logic eo, input bit expect_result);
        exp_t e;
        int   budget;
        budget = 0;
        @(negedge clk);
        while (!ready && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (!ready) begin
            checkOutput("ready_timeout", {31'd0, ready}, 32'd1);
        end else begin
            a     = av;
            b     = bv;
            bin   = binv;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            a     = 8'hC3;
            b     = 8'h3C;
            bin   = ~binv;
            if (expect_result) begin
                e.diff = ed;
                e.bout = eb;
                e.ovf  = eo;
                e.acc  = cyc;
                sb.push_back(e);
            end
        end
    endtask

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) checkOutput("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("diff", {24'd0, diff}, {24'd0, e.diff});
                checkOutput("bout", {31'd0, bout}, {31'd0, e.bout});
                checkOutput("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                checkOutput("latency_edges", cyc - e.acc + 1, WIDTH + 1);
                checkOutput("busy_in_done", {31'd0, busy}, 32'd1);
                checkOutput("ready_in_done", {31'd0, ready}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", {31'd0, ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_diff", {24'd0, diff}, 32'd0);
        checkOutput("reset_bout", {31'd0, bout}, 32'd0);
        checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;

        // Directed vectors: a, b, bin -> diff, bout, ovf
        applyStimulus(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b1); waitDone();
        applyStimulus(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1); waitDone();
        applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1); waitDone();
        applyStimulus(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1); waitDone();
        applyStimulus(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1); waitDone();
        applyStimulus(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1); waitDone();
        applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1); waitDone();

        // Start held high while busy is ignored; accepted again once ready.
        applyStimulus(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h01;
        bin   = 1'b0;
        waitDone();
        @(negedge clk);
        checkOutput("ready_after_done", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.diff = 8'hA9;
            e.bout = 1'b0;
            e.ovf  = 1'b0;
            e.acc  = cyc;
            sb.push_back(e);
        end
        start = 1'b0;
        waitDone();

        // Reset on the 4th SHIFT edge aborts with no done pulse.
        applyStimulus(8'h44, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_ready", {31'd0, ready}, 32'd1);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_diff", {24'd0, diff}, 32'd0);
        checkOutput("abort_bout", {31'd0, bout}, 32'd0);
        checkOutput("abort_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        applyStimulus(8'h09, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0, 1'b1); waitDone();

        // Simultaneous reset and start: reset wins.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h20;
        b     = 8'h10;
        @(negedge clk);
        checkOutput("rst_start_ready", {31'd0, ready}, 32'd1);
        checkOutput("rst_start_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_start_diff", {24'd0, diff}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;

        repeat (12) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial WIDTH-bit subtractor controller that computes diff = a − b − bin.
- One combinational 1-bit full-subtractor cell is time-shared over WIDTH cycles, LSB first.
- A registered borrow flop carries the borrow from one bit to the next.
- Sits between a requester, using a start/ready/done handshake, and that single cell.
- Reports the difference, the final borrow and signed overflow.

Parameters:
- WIDTH, 8, operand/result width in bits (legal ≥ 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only while ready=1.
- a  in  WIDTH  minuend; captured on an accepted start.
- b  in  WIDTH  subtrahend; captured on an accepted start.
- bin  in  1  borrow-in; captured on an accepted start.
- ready  out  1  high in IDLE only.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; result valid.
- diff  out  WIDTH  registered difference; held until the next result.
- bout  out  1  final borrow (unsigned a < b+bin).
- ovf  out  1  signed overflow.

Behaviour:
- All state changes on the rising edge of clk; no combinational path from inputs to outputs.
- Reset (rst=1 at an edge), from any state including mid-operation:
  - state=IDLE, counter=0, borrow flop=0, shift registers=0.
  - diff=0, bout=0, ovf=0, done=0.
  - ready=1 from the following cycle.
  - No done pulse for the aborted operation.
- FSM states:
  - IDLE: ready=1, busy=0. Accepted start (start=1 at edge E0): load a_sr←a, b_sr←b, borrow←bin, latch a[WIDTH-1] and b[WIDTH-1], cnt←0, go to SHIFT.
  - SHIFT: busy=1, ready=0. Each edge feeds cell X=a_sr[0], Y=b_sr[0], Z=borrow. Then:
    - d_sr shifts right with cell D entering at the MSB.
    - a_sr and b_sr shift right.
    - borrow←cell B; cnt←cnt+1.
    - On the edge where cnt==WIDTH-1 (edge E_WIDTH): go to DONE and register diff←final d_sr value (including this bit), bout←cell B, ovf←(a_msb≠b_msb)&&(diff_msb≠a_msb).
  - DONE: done=1, busy=1, ready=0 for exactly one cycle; next edge → IDLE.
- Latency: start sampled at E0 → done high during the cycle after E_WIDTH, i.e. WIDTH+1 edges after E0.
- Throughput: one operation per WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored; no queuing.
- Operand inputs may change freely after acceptance.
- Cell truth: D = X^Y^Z; B = (~X&Y) | (~X&Z) | (Y&Z).
- Arithmetic is modulo 2^WIDTH; bout=1 iff a < b+bin (unsigned).
- ovf uses the two's-complement interpretation of a and b; bin participates as a −1 term.
- diff, bout and ovf change only at the DONE-entry edge or at reset.
- Simultaneous rst and start: reset wins; start is not accepted.

Decomposition:
- Package serial_sub_pkg:
  - FSM state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Default WIDTH constant.
- Sub-module full_sub_cell: combinational 1-bit cell (inputs x, y, z; outputs d, b); instantiated once in serial_sub_ctrl.
- The FSM, counter and shift registers stay in serial_sub_ctrl.

Test Plan (WIDTH=8):
- Basic: a=0x35, b=0x12, bin=0 → done exactly 9 edges after the start edge; diff=0x23, bout=0, ovf=0.
- Unsigned underflow: a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0.
- Signed overflow: a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. Second case: a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- Borrow-in: a=0x05, b=0x05, bin=1 → diff=0xFF, bout=1, ovf=0.
- Handshake: pulse start with a=0x10, b=0x01, then start=1 with a=0xAA during SHIFT and during DONE:
  - ignored; single done pulse; diff=0x0F.
  - ready returns 1 the cycle after done.
  - a start accepted that cycle completes normally.
- Reset mid-op: start a=0x44, b=0x11, assert rst at the 4th SHIFT edge → next cycle state IDLE, ready=1, diff=0, bout=0, ovf=0, no done pulse. A fresh start a=0x09, b=0x03 → diff=0x06.
